prod_window_acc: RTL and testbench
==================================

// Module: prod_window_acc
// PURPOSE
//  Downstream consumer of the 8-bit product stream c produced by the add/multiply pipeline.
//  Sums WIN consecutive qualified samples into one window total.
//  Presents the total on a valid/ready output port and holds it until it is taken.
//  Sits between the product pipeline and the result sink or bus interface.
// PARAMETERS
//  WIN    16  samples per window; legal range 2..256
//  ACC_W  16  accumulator and output width; must be >= 8
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous reset, active-high
//  in_en      in   1      c_in is a valid sample this cycle
//  c_in       in   8      product sample, unsigned
//  sum_out    out  ACC_W  window total; stable while sum_valid=1
//  sum_valid  out  1      window total available
//  sum_ready  in   1      sink accepts sum_out when sum_valid && sum_ready
//  busy       out  1      window partially filled (state ACCUM)
//  dropped    out  1      1-cycle pulse: sample arrived in HOLD without handoff, discarded
//  sat_flag   out  1      sticky per window: total clipped (SAT_ACC_EN only, else tied 0)
// BEHAVIOUR
//  State machine, 2-bit state, three states:
//   - IDLE: no samples held.
//   - ACCUM: acc and cnt valid; cnt = samples taken so far, width $clog2(WIN+1).
//   - HOLD: sum_valid=1; acc frozen.
//  Reset: state=IDLE; acc=0; cnt=0.
//   - Output values after reset: sum_out=0, sum_valid=0, busy=0, dropped=0, sat_flag=0.
//   - Reset takes priority over every other input, including mid-window and HOLD. A held total is lost.
//  Transitions on in_en=1 (sample S = {(ACC_W-8)'b0, c_in}):
//   - IDLE: acc=S, cnt=1, go to ACCUM.
//   - ACCUM: acc=acc+S, cnt=cnt+1.
//   - ACCUM with cnt==WIN-1: add S, go to HOLD.
//   - in_en=0 in IDLE or ACCUM: no change. Gaps between samples are allowed.
//  Latency: sum_valid rises the cycle after the WIN-th sample is accepted.
//   - sum_out equals acc and is registered, with no combinational path from c_in.
//  HOLD:
//   - sum_ready=1, in_en=0: go to IDLE; acc=0, cnt=0, sat_flag=0.
//   - sum_ready=1, in_en=1: handoff and restart in the same cycle. acc=S, cnt=1, go to ACCUM; sample not dropped.
//   - sum_ready=0, in_en=1: sample discarded; dropped=1 next cycle for 1 cycle; acc unchanged.
//   - sum_ready=0: sum_out and sum_valid stay stable.
//  sum_ready outside HOLD is ignored.
//  busy = (state==ACCUM).
//  Arithmetic: unsigned, ACC_W bits. Without the macro, overflow wraps modulo 2^ACC_W.
// CONFIGURATION
//  SAT_ACC_EN defined:
//   - acc+S is computed at ACC_W+1 bits.
//   - If the carry is set, acc clamps to {ACC_W{1'b1}} and sat_flag=1.
//   - sat_flag stays set until the window is handed off or reset.
//  SAT_ACC_EN undefined:
//   - Wrap-around arithmetic; sat_flag held 0; no extra logic.
// TESTING (WIN=4, ACC_W=16 unless noted)
//  1. rst, then in_en with c_in 10,20,30,40 on consecutive cycles -> sum_valid=1 next cycle, sum_out=100, busy 1->0.
//  2. Same samples with a 2-cycle gap after 20 -> sum_out=100; sum_valid delayed by 2 cycles; busy=1 throughout the gap.
//  3. In HOLD with sum_ready=0, send c_in=5 -> dropped pulses once, sum_out stays 100; then sum_ready=1 -> IDLE, sum_valid=0.
//  4. In HOLD, sum_ready=1 and in_en=1 with c_in=7 in the same cycle -> sum_valid=0, busy=1, acc=7; then 1,1,1 -> sum_out=10.
//  5. Accept 2 samples (50,60), assert rst 1 cycle -> IDLE, busy=0; then 1,2,3,4 -> sum_out=10.
//  6. ACC_W=9, c_in=255 x4:
//     - With SAT_ACC_EN -> sum_out=511, sat_flag=1.
//     - Without the macro -> sum_out=508, sat_flag=0.

Source files
------------

// File: rtl/prod_window_acc.sv
// Sums WIN consecutive qualified 8-bit product samples and hands the total off on a valid/ready port.
// Optional SAT_ACC_EN: clamp the total at all-ones and raise a sticky sat_flag instead of wrapping.
module prod_window_acc #(
  parameter int unsigned WIN   = 16,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [7:0]       c_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             dropped,
  output logic             sat_flag
);

  localparam int unsigned CntW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             dropped_q;
  logic             sat_q;

  logic [ACC_W-1:0] sample;
  logic [ACC_W-1:0] acc_add;
  logic             sat_set;

  assign sample = ACC_W'(c_in);

`ifdef SAT_ACC_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, acc_q} + {1'b0, sample};
  assign acc_add  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign sat_set  = sum_wide[ACC_W];
`else
  assign acc_add  = acc_q + sample;
  assign sat_set  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_en) begin
            acc_q   <= sample;
            cnt_q   <= CntW'(1);
            sat_q   <= 1'b0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (in_en) begin
            acc_q <= acc_add;
            cnt_q <= cnt_q + CntW'(1);
            if (sat_set) sat_q <= 1'b1;
            if (cnt_q == CntW'(WIN - 1)) state_q <= StHold;
          end
        end
        StHold: begin
          if (sum_ready) begin
            // Handoff; a sample arriving in the same cycle opens the next window.
            sat_q <= 1'b0;
            if (in_en) begin
              acc_q   <= sample;
              cnt_q   <= CntW'(1);
              state_q <= StAccum;
            end else begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
            end
          end else if (in_en) begin
            dropped_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          acc_q   <= '0;
          cnt_q   <= '0;
          sat_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sum_out   = acc_q;
  assign sum_valid = (state_q == StHold);
  assign busy      = (state_q == StAccum);
  assign dropped   = dropped_q;

`ifdef SAT_ACC_EN
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_prod_window_acc.sv
// Directed bench for prod_window_acc: WIN=4/ACC_W=16 main instance plus an ACC_W=9 overflow instance.
module tb_prod_window_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en, sum_ready;
  logic [7:0]  c_in;
  logic [15:0] sum_out;
  logic        sum_valid, busy, dropped, sat_flag;

  logic        en9, rdy9;
  logic [7:0]  c9;
  logic [8:0]  sum9;
  logic        valid9, busy9, dropped9, sat9;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prod_window_acc #(.WIN(4), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .c_in(c_in), .sum_out(sum_out),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .dropped(dropped),
    .sat_flag(sat_flag)
  );

  prod_window_acc #(.WIN(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst(rst), .in_en(en9), .c_in(c9), .sum_out(sum9),
    .sum_valid(valid9), .sum_ready(rdy9), .busy(busy9), .dropped(dropped9),
    .sat_flag(sat9)
  );

  // Drive one cycle of main-instance inputs; outputs are then sampled 1 time unit after the edge.
  task automatic step(input logic en, input logic [7:0] c, input logic rdy);
    in_en = en; c_in = c; sum_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic step9(input logic en, input logic [7:0] c, input logic rdy);
    en9 = en; c9 = c; rdy9 = rdy;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 8'd99, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    chk("rst_sum", sum_out, 16'd0);
    chk("rst_valid", {15'd0, sum_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_dropped", {15'd0, dropped}, 16'd0);
    chk("rst_sat", {15'd0, sat_flag}, 16'd0);
  endtask

  task automatic test_basic();
    step(1'b1, 8'd10, 1'b0);
    chk("t1_busy0", {15'd0, busy}, 16'd1);
    chk("t1_sum0", sum_out, 16'd10);
    step(1'b1, 8'd20, 1'b0);
    step(1'b1, 8'd30, 1'b0);
    chk("t1_busy2", {15'd0, busy}, 16'd1);
    chk("t1_valid2", {15'd0, sum_valid}, 16'd0);
    step(1'b1, 8'd40, 1'b0);
    chk("t1_valid", {15'd0, sum_valid}, 16'd1);
    chk("t1_sum", sum_out, 16'd100);
    chk("t1_busy_end", {15'd0, busy}, 16'd0);
    step(1'b0, 8'd0, 1'b1);
    chk("t1_take_valid", {15'd0, sum_valid}, 16'd0);
    chk("t1_take_sum", sum_out, 16'd0);
  endtask

  task automatic test_gap();
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd20, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'd77, 1'b1);
      chk("t2_gap_busy", {15'd0, busy}, 16'd1);
      chk("t2_gap_valid", {15'd0, sum_valid}, 16'd0);
      chk("t2_gap_sum", sum_out, 16'd30);
    end
    step(1'b1, 8'd30, 1'b0);
    chk("t2_valid_early", {15'd0, sum_valid}, 16'd0);
    step(1'b1, 8'd40, 1'b0);
    chk("t2_valid", {15'd0, sum_valid}, 16'd1);
    chk("t2_sum", sum_out, 16'd100);
  endtask

  task automatic test_drop();
    step(1'b1, 8'd5, 1'b0);
    chk("t3_dropped", {15'd0, dropped}, 16'd1);
    chk("t3_hold_sum", sum_out, 16'd100);
    chk("t3_hold_valid", {15'd0, sum_valid}, 16'd1);
    step(1'b0, 8'd0, 1'b0);
    chk("t3_drop_pulse", {15'd0, dropped}, 16'd0);
    chk("t3_hold_sum2", sum_out, 16'd100);
    step(1'b0, 8'd0, 1'b1);
    chk("t3_idle_valid", {15'd0, sum_valid}, 16'd0);
    chk("t3_idle_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd20, 1'b0);
    step(1'b1, 8'd30, 1'b0);
    step(1'b1, 8'd40, 1'b0);
    chk("t4_hold", {15'd0, sum_valid}, 16'd1);
    step(1'b1, 8'd7, 1'b1);
    chk("t4_valid", {15'd0, sum_valid}, 16'd0);
    chk("t4_busy", {15'd0, busy}, 16'd1);
    chk("t4_acc", sum_out, 16'd7);
    chk("t4_nodrop", {15'd0, dropped}, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd1, 1'b0);
    chk("t4_valid2", {15'd0, sum_valid}, 16'd1);
    chk("t4_sum", sum_out, 16'd10);
    step(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_mid_reset();
    step(1'b1, 8'd50, 1'b0);
    step(1'b1, 8'd60, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'd9, 1'b1);
    rst = 1'b0;
    chk("t5_busy", {15'd0, busy}, 16'd0);
    chk("t5_sum", sum_out, 16'd0);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b1, 8'd4, 1'b0);
    chk("t5_valid", {15'd0, sum_valid}, 16'd1);
    chk("t5_sum2", sum_out, 16'd10);
    // Reset during HOLD discards the held total.
    rst = 1'b1;
    step(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    chk("t5_hold_rst_valid", {15'd0, sum_valid}, 16'd0);
    chk("t5_hold_rst_sum", sum_out, 16'd0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step9(1'b1, 8'd255, 1'b0);
    chk("t6_valid", {15'd0, valid9}, 16'd1);
`ifdef SAT_ACC_EN
    chk("t6_sum", {7'd0, sum9}, 16'd511);
    chk("t6_sat", {15'd0, sat9}, 16'd1);
`else
    chk("t6_sum", {7'd0, sum9}, 16'd508);
    chk("t6_sat", {15'd0, sat9}, 16'd0);
`endif
    step9(1'b0, 8'd0, 1'b1);
    chk("t6_sat_clear", {15'd0, sat9}, 16'd0);
    chk("t6_idle", {15'd0, valid9}, 16'd0);
    chk("t6_main_sat", {15'd0, sat_flag}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; c_in = 8'd0; sum_ready = 1'b0;
    en9 = 1'b0; c9 = 8'd0; rdy9 = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_drop();
    test_back_to_back();
    test_mid_reset();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
